mult_share_sched: RTL and testbench
===================================

# mult_share_sched

Scheduler and sequencer that shares one shift-add multiplier datapath between two requesters. It arbitrates round-robin between two REQ/ACK ports, loads the winning operands, steps the add/shift datapath for WIDTH cycles, and returns the product with a one-cycle ACK. It sits in the CLK_S (divided-clock) domain between the switch/button front-end and the multiplier slave circuit, replacing single-user FSM control.

## Interface
- WIDTH, 5, operand width; product is 2*WIDTH bits
- CLK  in  1  system clock (divided clock in top level), rising edge
- RST_N  in  1  asynchronous active-low reset
- REQ0, REQ1  in  1  level request; held high until matching ACK seen
- A0, B0, A1, B1  in  WIDTH  unsigned operands per requester; stable while REQn high
- ACK0, ACK1  out  1  one-cycle pulse: PROD valid for that requester
- PROD  out  2*WIDTH  registered product; holds last result until next completion
- BUSY  out  1  high whenever state != IDLE
- OWNER  out  1  current/last grantee (0 or 1)

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: no REQ -> stay. One REQ -> grant it. Both -> grant requester != LAST (LAST resets to 1, so REQ0 wins first tie). On grant: OWNER <= grantee, -> LOAD.
- LOAD (1 cycle): on exit edge, MCAND <= zero-extended A[OWNER] (2*WIDTH bits), MPLIER <= B[OWNER], ACC <= 0, CNT <= 0; -> SHIFT.
- SHIFT (exactly WIDTH cycles): each edge, if MPLIER[0] then ACC <= ACC + MCAND; MCAND <= MCAND << 1; MPLIER <= MPLIER >> 1; CNT <= CNT + 1. On edge where CNT == WIDTH-1: PROD <= final sum (ACC + conditional MCAND), -> DONE.
- DONE (1 cycle): ACKn = (state == DONE) && (OWNER == n); LAST <= OWNER on exit; -> IDLE.
- Arithmetic unsigned; ACC 2*WIDTH bits never overflows (max (2^W-1)^2).
- REQ changes during LOAD/SHIFT/DONE ignored; dropped REQ of the owner does not abort operation (ACK still issued).
- Requester must deassert REQ within 1 cycle after ACK, else re-arbitrated as a new request.
- Reset (async, any state): state IDLE, ACK0/ACK1 0, PROD 0, BUSY 0, OWNER 0, LAST 1, ACC/MCAND/MPLIER/CNT 0. In-flight operation discarded, no ACK.

## Timing
- REQ sampled at edge k in IDLE -> LOAD after k, operands latched at k+1, shifts at k+2..k+WIDTH+1, DONE after k+WIDTH+1 (k+6 for WIDTH=5).
- ACK high for exactly one cycle between edges k+WIDTH+1 and k+WIDTH+2; PROD valid from k+WIDTH+1 onward.
- Back to IDLE at k+WIDTH+2; next grant sampled at k+WIDTH+3 earliest. Service period WIDTH+3 cycles (8 for WIDTH=5).
- BUSY rises after edge k, falls after edge k+WIDTH+2.
- All outputs registered or decoded from state/OWNER only; no combinational path REQ -> ACK.

## Test plan
- Reset: hold RST_N low, toggle CLK -> ACK0=ACK1=0, PROD=0, BUSY=0, OWNER=0; release, no REQ for 20 cycles -> outputs unchanged.
- Single request: REQ0=1, A0=31, B0=31 sampled at edge k -> ACK0 pulse after edge k+6 only, PROD=961, ACK1 never high; A0=0, B0=31 -> PROD=0.
- Simultaneous: REQ0 (7x9) and REQ1 (12x5) both high at edge k -> ACK0 after k+6 with PROD=63; REQ0 dropped; ACK1 after k+14 with PROD=60; OWNER 0 then 1.
- Round-robin fairness: both REQs reasserted immediately after each ACK for 6 operations -> grants alternate 0,1,0,1,0,1; no requester starved.
- Reset mid-operation: REQ1=1 (A1=21, B1=13); assert RST_N low during 3rd SHIFT cycle -> BUSY 0 immediately, no ACK1, PROD=0; after release with REQ1 still high -> restart, ACK1 8 cycles later with PROD=273.
- Operand change during SHIFT: REQ0 with 10x10, change A0/B0 to 31 after LOAD edge -> PROD=100.

Source files
------------

// File: rtl/mult_share_sched.sv
// Two-requester scheduler around one shared shift-add multiplier.
// Requests are granted round-robin. The winner's operands are loaded, the
// datapath runs for WIDTH steps, and the product comes back with a one-cycle
// ACK to that requester.

// Shift-add datapath: one multiplier bit is consumed per step.
module mult_share_dp #(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] sum,
  output logic               last_step
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  // Accumulator value after the current step. The last step's value is
  // taken directly into the product register, so no extra cycle is needed.
  always_comb begin
    sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign last_step = (cnt_q == CW'(WIDTH - 1));

  // Load the operands, then add, shift and count on each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      mcand_q  <= {{WIDTH{1'b0}}, mcand_in};
      mplier_q <= mplier_in;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end
endmodule

module mult_share_sched #(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               ack0,
  output logic               ack1,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy,
  output logic               owner
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         req_v;
  logic [1:0][WIDTH-1:0] a_v, b_v;
  logic               grant_vld;
  logic               grant_id;
  logic               owner_q;
  logic               last_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] sum;
  logic               last_step;

  assign req_v = {req1, req0};
  assign a_v   = {a1, a0};
  assign b_v   = {b1, b0};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and arbitration. Requests are only looked at in IDLE. On a
  // tie the requester that was not served last wins.
  always_comb begin
    state_d   = state_q;
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_v) begin
          grant_vld = 1'b1;
          grant_id  = (&req_v) ? ~last_q : req_v[1];
          state_d   = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant bookkeeping: the current owner, and the last owner for round-robin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      if (grant_vld)          owner_q <= grant_id;
      if (state_q == S_DONE)  last_q  <= owner_q;
    end
  end

  // The product register holds the last result until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 prod_q <= '0;
    else if (state_q == S_SHIFT && last_step)   prod_q <= sum;
  end

  mult_share_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (state_q == S_LOAD),
    .step      (state_q == S_SHIFT),
    .mcand_in  (a_v[owner_q]),
    .mplier_in (b_v[owner_q]),
    .sum       (sum),
    .last_step (last_step)
  );

  // Outputs come only from the state and owner registers, so there is no
  // combinational path from REQ to ACK.
  assign ack0  = (state_q == S_DONE) && !owner_q;
  assign ack1  = (state_q == S_DONE) &&  owner_q;
  assign busy  = (state_q != S_IDLE);
  assign owner = owner_q;
  assign prod  = prod_q;
endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: directed scenarios plus random traffic.
// All outputs are checked every cycle against a transaction-level model.
module tb_mult_share_sched;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic           ack0, ack1, busy, owner;
  logic [2*W-1:0] prod;

  mult_share_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .prod(prod), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. It works with edge numbers relative to the grant edge
  // instead of with states. The grant happens at edge g, the operands are
  // captured at g+1, the product is ready at g+W+1, and the block is free
  // again after g+W+2.
  int             ecnt = 0;
  int             t_grant;
  int             m_owner, m_last, m_a, m_b;
  logic [2*W-1:0] m_prod;
  bit             e_ack0, e_ack1, e_busy;

  task automatic model_reset();
    t_grant = -1; m_owner = 0; m_last = 1; m_prod = '0;
    e_ack0 = 0; e_ack1 = 0; e_busy = 0;
  endtask

  task automatic model_edge();
    ecnt++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (t_grant < 0) begin
      if (req0 || req1) begin
        m_owner = (req0 && req1) ? int'(m_last == 0) : (req1 ? 1 : 0);
        t_grant = ecnt;
      end
    end else begin
      if (ecnt == t_grant + 1) begin
        m_a = (m_owner == 1) ? int'(a1) : int'(a0);
        m_b = (m_owner == 1) ? int'(b1) : int'(b0);
      end
      if (ecnt == t_grant + W + 1) m_prod = (2*W)'(m_a * m_b);
      if (ecnt == t_grant + W + 2) begin
        m_last  = m_owner;
        t_grant = -1;
      end
    end
    e_busy = (t_grant >= 0);
    e_ack0 = (t_grant >= 0) && (ecnt == t_grant + W + 1) && (m_owner == 0);
    e_ack1 = (t_grant >= 0) && (ecnt == t_grant + W + 1) && (m_owner == 1);
  endtask

  task automatic compare_all();
    chk("ack0",  32'(ack0),  32'(e_ack0));
    chk("ack1",  32'(ack1),  32'(e_ack1));
    chk("busy",  32'(busy),  32'(e_busy));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("prod",  32'(prod),  32'(m_prod));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Run until the model expects ACK for requester n. Returns the number of edges.
  task automatic wait_ack(input int n, input int max, output int lat);
    bit hit;
    lat = 0;
    hit = 0;
    while (!hit && lat < max) begin
      tick();
      lat++;
      hit = (n == 0) ? e_ack0 : e_ack1;
    end
    chk("ack_wait", 32'(hit), 32'd1);
  endtask

  task automatic wait_any(input int max);
    int  n;
    bit  hit;
    n = 0;
    hit = 0;
    while (!hit && n < max) begin
      tick();
      n++;
      hit = e_ack0 || e_ack1;
    end
    chk("any_ack_wait", 32'(hit), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    model_reset();

    // Reset and then a quiet period.
    #1;
    compare_all();
    idle(3);
    rst_n = 1'b1;
    idle(20);

    // Single request: latency, maximum operands, and a zero operand.
    a0 = 5'd31; b0 = 5'd31; req0 = 1'b1;
    wait_ack(0, 20, lat);
    chk("single_lat", 32'(lat), 32'd7);
    chk("single_961", 32'(prod), 32'd961);
    req0 = 1'b0;
    idle(3);
    a0 = 5'd0; b0 = 5'd31; req0 = 1'b1;
    wait_ack(0, 20, lat);
    chk("zero_prod", 32'(prod), 32'd0);
    req0 = 1'b0;
    idle(3);

    // Simultaneous requests after reset: REQ0 wins the first tie.
    do_reset();
    a0 = 5'd7;  b0 = 5'd9;  a1 = 5'd12; b1 = 5'd5;
    req0 = 1'b1; req1 = 1'b1;
    wait_ack(0, 20, lat);
    chk("sim_lat0", 32'(lat), 32'd7);
    chk("sim_p0",   32'(prod), 32'd63);
    chk("sim_own0", 32'(owner), 32'd0);
    req0 = 1'b0;
    wait_ack(1, 20, lat);
    chk("sim_lat1", 32'(lat), 32'd8);
    chk("sim_p1",   32'(prod), 32'd60);
    chk("sim_own1", 32'(owner), 32'd1);
    req1 = 1'b0;
    idle(3);

    // Round-robin: both requesters keep requesting, so grants alternate.
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_any(20);
      chk("rr_owner", 32'(owner), 32'(i % 2));
      if (e_ack0) begin a0 = W'($urandom); b0 = W'($urandom); end
      if (e_ack1) begin a1 = W'($urandom); b1 = W'($urandom); end
    end
    req0 = 1'b0; req1 = 1'b0;
    idle(3);

    // Reset in the middle of an operation, then restart.
    a1 = 5'd21; b1 = 5'd13; req1 = 1'b1;
    idle(4);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ack1", 32'(ack1), 32'd0);
    chk("mid_prod", 32'(prod), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_ack(1, 20, lat);
    chk("mid_273", 32'(prod), 32'd273);
    req1 = 1'b0;
    idle(3);

    // Operands change after the load edge: the captured values are used.
    a0 = 5'd10; b0 = 5'd10; req0 = 1'b1;
    tick();
    tick();
    a0 = 5'd31; b0 = 5'd31;
    wait_ack(0, 20, lat);
    chk("opchg_100", 32'(prod), 32'd100);
    req0 = 1'b0;
    idle(3);

    // Random traffic. A requester drops its request on ACK, and it may
    // request again on a later cycle with new operands.
    for (int c = 0; c < 500; c++) begin
      tick();
      if (req0 && e_ack0) req0 = 1'b0;
      else if (!req0 && $urandom_range(2) == 0) begin
        a0 = W'($urandom); b0 = W'($urandom); req0 = 1'b1;
      end
      if (req1 && e_ack1) req1 = 1'b0;
      else if (!req1 && $urandom_range(2) == 0) begin
        a1 = W'($urandom); b1 = W'($urandom); req1 = 1'b1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
